// File: rtl/tx_ack_retry_ctrl.sv
// Per-packet transmit-attempt controller. Follows one packet through the first
// transmission, the ACK / Block-ACK wait, any timeouts and retransmissions, and
// then reports the result upstream of the tx status FIFOs.
//
// Ports:
//   clk, rstn            clock; synchronous active-low reset
//   tx_start             pulse, first attempt of a new packet (ignored unless idle)
//   ack_required,
//   is_ampdu, max_retry,
//   cw_min, cw_max       per-packet configuration, captured on an accepted tx_start
//   ack_timeout_cycles   ACK window length, captured on entry to the ACK wait
//   phy_tx_done          pulse, PHY finished the current attempt
//   rx_ack_ok            pulse, valid ACK addressed to us
//   rx_blk_ack_ok        pulse, valid Block-ACK addressed to us
//   rx_blk_ack_ssn/_bitmap  Block-ACK contents, valid with rx_blk_ack_ok
//   retrans_req          pulse, upstream must re-send the same packet
//   busy                 a packet is in flight
//   cw                   current contention-window exponent
//   tx_try_complete      pulse, packet finished
//   tx_success           result, valid with tx_try_complete
//   tx_status            {bitmap[79:16], ssn[15:4], num_retrans[3:0]}
// All outputs are registered.
module tx_ack_retry_ctrl #(
  parameter int unsigned TIMER_W = 16,
  parameter int unsigned CW_W    = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               tx_start,
  input  logic               ack_required,
  input  logic               is_ampdu,
  input  logic [3:0]         max_retry,
  input  logic [CW_W-1:0]    cw_min,
  input  logic [CW_W-1:0]    cw_max,
  input  logic [TIMER_W-1:0] ack_timeout_cycles,
  input  logic               phy_tx_done,
  input  logic               rx_ack_ok,
  input  logic               rx_blk_ack_ok,
  input  logic [11:0]        rx_blk_ack_ssn,
  input  logic [63:0]        rx_blk_ack_bitmap,
  output logic               retrans_req,
  output logic               busy,
  output logic [CW_W-1:0]    cw,
  output logic               tx_try_complete,
  output logic               tx_success,
  output logic [79:0]        tx_status
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitTxDone,
    StWaitAck,
    StRetry,
    StDone
  } state_e;

  state_e             state_q;
  logic               ack_req_q;
  logic               ampdu_q;
  logic [3:0]         max_retry_q;
  logic [CW_W-1:0]    cw_max_q;
  logic [TIMER_W-1:0] timer_q;
  logic [3:0]         num_retrans_q;

  logic               ack_match;
  logic [CW_W-1:0]    cw_next;

  // Only the ack type the packet is waiting for counts; the other is ignored.
  assign ack_match = ampdu_q ? rx_blk_ack_ok : rx_ack_ok;

  // Saturating increment; also clamps a cw_min that was configured above cw_max.
  assign cw_next = (cw >= cw_max_q) ? cw_max_q : cw + CW_W'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= StIdle;
      ack_req_q       <= 1'b0;
      ampdu_q         <= 1'b0;
      max_retry_q     <= '0;
      cw_max_q        <= '0;
      timer_q         <= '0;
      num_retrans_q   <= '0;
      retrans_req     <= 1'b0;
      busy            <= 1'b0;
      cw              <= '0;
      tx_try_complete <= 1'b0;
      tx_success      <= 1'b0;
      tx_status       <= '0;
    end else begin
      retrans_req     <= 1'b0;
      tx_try_complete <= 1'b0;

      case (state_q)
        StIdle: begin
          if (tx_start) begin
            ack_req_q     <= ack_required;
            ampdu_q       <= is_ampdu;
            max_retry_q   <= max_retry;
            cw_max_q      <= cw_max;
            cw            <= cw_min;
            num_retrans_q <= '0;
            busy          <= 1'b1;
            state_q       <= StWaitTxDone;
          end
        end

        StWaitTxDone: begin
          if (phy_tx_done) begin
            if (!ack_req_q) begin
              tx_try_complete <= 1'b1;
              tx_success      <= 1'b1;
              tx_status       <= {76'b0, num_retrans_q};
              state_q         <= StDone;
            end else begin
              timer_q <= ack_timeout_cycles;
              state_q <= StWaitAck;
            end
          end
        end

        StWaitAck: begin
          // An ack arriving in the same cycle the timer expires still wins.
          if (ack_match) begin
            tx_try_complete <= 1'b1;
            tx_success      <= 1'b1;
            tx_status       <= ampdu_q ? {rx_blk_ack_bitmap, rx_blk_ack_ssn, num_retrans_q}
                                       : {76'b0, num_retrans_q};
            state_q         <= StDone;
          end else if (timer_q == '0) begin
            if (num_retrans_q < max_retry_q) begin
              num_retrans_q <= num_retrans_q + 4'd1;
              cw            <= cw_next;
              retrans_req   <= 1'b1;
              state_q       <= StRetry;
            end else begin
              tx_try_complete <= 1'b1;
              tx_success      <= 1'b0;
              tx_status       <= {76'b0, num_retrans_q};
              state_q         <= StDone;
            end
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
          end
        end

        StRetry: begin
          state_q <= StWaitTxDone;
        end

        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_ack_retry_ctrl.sv
// Self-checking bench for tx_ack_retry_ctrl: a table of packet scenarios with
// expected completion records queued on a scoreboard, plus hand-written
// sequences for the late-ack, busy-start and mid-packet reset corners.
module tb_tx_ack_retry_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tx_start;
  logic        ack_required;
  logic        is_ampdu;
  logic [3:0]  max_retry;
  logic [3:0]  cw_min;
  logic [3:0]  cw_max;
  logic [15:0] ack_timeout_cycles;
  logic        phy_tx_done;
  logic        rx_ack_ok;
  logic        rx_blk_ack_ok;
  logic [11:0] rx_blk_ack_ssn;
  logic [63:0] rx_blk_ack_bitmap;
  logic        retrans_req;
  logic        busy;
  logic [3:0]  cw;
  logic        tx_try_complete;
  logic        tx_success;
  logic [79:0] tx_status;

  always #5 clk = ~clk;

  tx_ack_retry_ctrl #(
    .TIMER_W(16),
    .CW_W   (4)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .tx_start          (tx_start),
    .ack_required      (ack_required),
    .is_ampdu          (is_ampdu),
    .max_retry         (max_retry),
    .cw_min            (cw_min),
    .cw_max            (cw_max),
    .ack_timeout_cycles(ack_timeout_cycles),
    .phy_tx_done       (phy_tx_done),
    .rx_ack_ok         (rx_ack_ok),
    .rx_blk_ack_ok     (rx_blk_ack_ok),
    .rx_blk_ack_ssn    (rx_blk_ack_ssn),
    .rx_blk_ack_bitmap (rx_blk_ack_bitmap),
    .retrans_req       (retrans_req),
    .busy              (busy),
    .cw                (cw),
    .tx_try_complete   (tx_try_complete),
    .tx_success        (tx_success),
    .tx_status         (tx_status)
  );

  typedef struct {
    string       name;
    logic        ack_req;
    logic        ampdu;
    logic [3:0]  max_retry;
    logic [3:0]  cw_min;
    logic [3:0]  cw_max;
    logic [15:0] tmo;
    int          ack_att;     // attempt that receives the ack (>15: never)
    int          ack_dly;     // cycles after WAIT_ACK entry
    logic        send_wrong;  // also send the other ack type at entry
    logic [11:0] ssn;
    logic [63:0] bm;
    logic        exp_succ;
    logic [79:0] exp_status;
    logic [3:0]  exp_cw;
    int          exp_retx;
  } vec_t;

  typedef struct {
    string       name;
    logic        succ;
    logic [79:0] status;
    logic [3:0]  cw;
    int          retx;
  } exp_t;

  exp_t       sb[$];
  vec_t       vecs[11];
  int         checks   = 0;
  int         failures = 0;
  int         retx_cnt = 0;
  logic [3:0] m_cw;
  logic [3:0] m_cwmax;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Runs every cycle: counts retries, tracks the cw model, checks completions.
  task automatic monitor();
    exp_t e;
    if (retrans_req) begin
      retx_cnt++;
      m_cw = (m_cw >= m_cwmax) ? m_cwmax : m_cw + 4'd1;
      chk("retry_cw", 80'(cw), 80'(m_cw));
    end
    if (tx_try_complete) begin
      if (sb.size() == 0) begin
        chk("unexpected_complete", 80'(tx_try_complete), 80'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_success"}, 80'(tx_success), 80'(e.succ));
        chk({e.name, "_status"}, tx_status, e.status);
        chk({e.name, "_cw"}, 80'(cw), 80'(e.cw));
        chk({e.name, "_retx"}, 80'(retx_cnt), 80'(e.retx));
      end
      retx_cnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic clear_rx();
    rx_ack_ok     = 1'b0;
    rx_blk_ack_ok = 1'b0;
  endtask

  task automatic push_exp(input string nm, input logic s, input logic [79:0] st,
                          input logic [3:0] c, input int r);
    exp_t e;
    e.name   = nm;
    e.succ   = s;
    e.status = st;
    e.cw     = c;
    e.retx   = r;
    sb.push_back(e);
  endtask

  task automatic start_pkt(input logic ar, input logic am, input logic [3:0] mr,
                           input logic [3:0] cmin, input logic [3:0] cmax,
                           input logic [15:0] tmo);
    ack_required       = ar;
    is_ampdu           = am;
    max_retry          = mr;
    cw_min             = cmin;
    cw_max             = cmax;
    ack_timeout_cycles = tmo;
    m_cw               = cmin;
    m_cwmax            = cmax;
    retx_cnt           = 0;
    tx_start           = 1'b1;
    tick();
    tx_start           = 1'b0;
  endtask

  task automatic phy_done();
    phy_tx_done = 1'b1;
    tick();
    phy_tx_done = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) tick();
    if (busy) chk("idle_timeout", 80'(busy), 80'd0);
  endtask

  task automatic drive_ack(input vec_t v, input logic right);
    // right: the ack type this packet waits for; otherwise the other type.
    if (right ^ v.ampdu) begin
      rx_ack_ok = 1'b1;
    end else begin
      rx_blk_ack_ok     = 1'b1;
      rx_blk_ack_ssn    = v.ssn;
      rx_blk_ack_bitmap = v.bm;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    bit done;
    push_exp(v.name, v.exp_succ, v.exp_status, v.exp_cw, v.exp_retx);
    start_pkt(v.ack_req, v.ampdu, v.max_retry, v.cw_min, v.cw_max, v.tmo);
    done = 1'b0;
    for (int att = 0; att < 16 && !done; att++) begin
      phy_done();
      if (!v.ack_req) begin
        chk({v.name, "_noack_latency"}, 80'(tx_try_complete), 80'd1);
        done = 1'b1;
      end else if (att == v.ack_att) begin
        for (int s = 0; s <= v.ack_dly; s++) begin
          if (v.send_wrong && s == 0) drive_ack(v, 1'b0);
          if (s == v.ack_dly) drive_ack(v, 1'b1);
          tick();
          clear_rx();
        end
        chk({v.name, "_ack_latency"}, 80'(tx_try_complete), 80'd1);
        done = 1'b1;
      end else begin
        k = 0;
        while (k < int'(v.tmo) + 8) begin
          if (v.send_wrong && k == 0) drive_ack(v, 1'b0);
          tick();
          clear_rx();
          k++;
          if (retrans_req || tx_try_complete) break;
        end
        chk({v.name, "_timeout_latency"}, 80'(k), 80'(int'(v.tmo) + 1));
        if (retrans_req && !tx_try_complete) tick();
        else done = 1'b1;
      end
    end
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        name                  ar am mr cmin cmax tmo  att dly wr ssn      bm
    //        succ status                          cw  retx
    vecs[0]  = '{"plain_ack",          1, 0, 3, 2, 7, 10, 0, 5, 0, 12'h0, 64'h0,
                 1, 80'h0, 2, 0};
    vecs[1]  = '{"no_ack_exhaust",     1, 0, 3, 4, 6, 6, 99, 0, 0, 12'h0, 64'h0,
                 0, 80'h3, 6, 3};
    vecs[2]  = '{"ba_after_retry",     1, 1, 2, 3, 5, 4, 1, 2, 1, 12'hABC,
                 64'h0123_4567_89AB_CDEF,
                 1, 80'h0123_4567_89AB_CDEF_ABC1, 4, 1};
    vecs[3]  = '{"tmo0_ack_at_t",      1, 0, 2, 1, 3, 0, 0, 0, 0, 12'h0, 64'h0,
                 1, 80'h0, 1, 0};
    vecs[4]  = '{"ack_at_timer_zero",  1, 0, 2, 1, 3, 3, 0, 3, 0, 12'h0, 64'h0,
                 1, 80'h0, 1, 0};
    vecs[5]  = '{"no_ack_required",    0, 0, 3, 5, 9, 7, 0, 0, 0, 12'h0, 64'h0,
                 1, 80'h0, 5, 0};
    vecs[6]  = '{"max_retry_zero",     1, 0, 0, 2, 8, 2, 99, 0, 0, 12'h0, 64'h0,
                 0, 80'h0, 2, 0};
    vecs[7]  = '{"ba_first_try",       1, 1, 1, 6, 8, 5, 0, 1, 1, 12'h123,
                 64'hFFFF_0000_A5A5_5A5A,
                 1, 80'hFFFF_0000_A5A5_5A5A_1230, 6, 0};
    vecs[8]  = '{"ba_fail",            1, 1, 1, 0, 2, 3, 99, 0, 1, 12'h555,
                 64'hDEAD_BEEF_0000_1111,
                 0, 80'h1, 1, 1};
    vecs[9]  = '{"cw_min_above_max",   1, 0, 2, 7, 5, 1, 99, 0, 0, 12'h0, 64'h0,
                 0, 80'h2, 5, 2};
    vecs[10] = '{"ack_ignores_ba",     1, 0, 2, 0, 15, 5, 2, 3, 1, 12'h7FF,
                 64'hFFFF_FFFF_FFFF_FFFF,
                 1, 80'h2, 2, 2};

    rstn               = 1'b0;
    tx_start           = 1'b0;
    ack_required       = 1'b0;
    is_ampdu           = 1'b0;
    max_retry          = '0;
    cw_min             = '0;
    cw_max             = '0;
    ack_timeout_cycles = '0;
    phy_tx_done        = 1'b0;
    rx_ack_ok          = 1'b0;
    rx_blk_ack_ok      = 1'b0;
    rx_blk_ack_ssn     = '0;
    rx_blk_ack_bitmap  = '0;
    m_cw               = '0;
    m_cwmax            = '0;
    repeat (3) tick();

    chk("reset_busy", 80'(busy), 80'd0);
    chk("reset_cw", 80'(cw), 80'd0);
    chk("reset_status", tx_status, 80'd0);
    chk("reset_complete", 80'(tx_try_complete), 80'd0);
    chk("reset_retrans", 80'(retrans_req), 80'd0);
    chk("reset_success", 80'(tx_success), 80'd0);
    rstn = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Zero-length window: an ack one cycle late lands in RETRY and is dropped.
    push_exp("late_ack", 1'b1, 80'h1, 4'd2, 1);
    start_pkt(1'b1, 1'b0, 4'd1, 4'd1, 4'd3, 16'd0);
    phy_done();
    tick();
    chk("late_ack_retry", 80'(retrans_req), 80'd1);
    rx_ack_ok = 1'b1;
    tick();
    clear_rx();
    chk("late_ack_ignored", 80'(tx_try_complete), 80'd0);
    chk("late_ack_busy", 80'(busy), 80'd1);
    phy_done();
    rx_ack_ok = 1'b1;
    tick();
    clear_rx();
    chk("late_ack_final_latency", 80'(tx_try_complete), 80'd1);
    wait_idle();

    // Reset while waiting for the ack abandons the packet silently.
    start_pkt(1'b1, 1'b0, 4'd2, 4'd5, 4'd7, 16'd20);
    phy_done();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("midreset_busy", 80'(busy), 80'd0);
    chk("midreset_cw", 80'(cw), 80'd0);
    chk("midreset_status", tx_status, 80'd0);
    chk("midreset_success", 80'(tx_success), 80'd0);
    chk("midreset_retrans", 80'(retrans_req), 80'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midreset_no_complete", 80'(tx_try_complete), 80'd0);
    end
    run_vec(vecs[2]);

    // tx_start while busy must not touch the latched configuration.
    push_exp("busy_start", 1'b0, 80'h0, 4'd3, 0);
    start_pkt(1'b1, 1'b0, 4'd0, 4'd3, 4'd6, 16'd2);
    ack_required = 1'b0;
    max_retry    = 4'd5;
    cw_min       = 4'd9;
    cw_max       = 4'd12;
    tx_start     = 1'b1;
    tick();
    tx_start     = 1'b0;
    chk("busy_start_cw", 80'(cw), 80'd3);
    phy_done();
    chk("busy_start_ack_req_kept", 80'(tx_try_complete), 80'd0);
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_try_complete || retrans_req) break;
    end
    chk("busy_start_done", 80'(tx_try_complete), 80'd1);
    wait_idle();

    chk("scoreboard_drained", 80'(sb.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_ack_retry_ctrl.md
Name: tx_ack_retry_ctrl

Overview:
- Per-packet transmit-attempt controller that sits directly upstream of the tx status FIFOs.
- Tracks one packet from first transmission through ACK / Block-ACK wait, timeout and retransmission.
- Maintains the contention-window exponent and retry count for that packet.
- On finishing a packet, emits a one-cycle tx_try_complete pulse with an 80-bit tx_status word: retry count, BA SSN, 64-bit BA bitmap.

Parameters:
- TIMER_W, 16, width of ACK-timeout counter and ack_timeout_cycles.
- CW_W, 4, width of contention-window exponent.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- tx_start  in  1  pulse: first attempt of a new packet begins
- ack_required  in  1  sampled at accepted tx_start
- is_ampdu  in  1  sampled at accepted tx_start; expects Block-ACK instead of ACK
- max_retry  in  4  sampled at accepted tx_start
- cw_min  in  CW_W  sampled at accepted tx_start
- cw_max  in  CW_W  sampled at accepted tx_start
- ack_timeout_cycles  in  TIMER_W  sampled when WAIT_ACK is entered
- phy_tx_done  in  1  pulse: PHY finished current attempt
- rx_ack_ok  in  1  pulse: valid ACK addressed to us
- rx_blk_ack_ok  in  1  pulse: valid Block-ACK addressed to us
- rx_blk_ack_ssn  in  12  valid with rx_blk_ack_ok
- rx_blk_ack_bitmap  in  64  valid with rx_blk_ack_ok
- retrans_req  out  1  pulse: upstream must re-send same packet
- busy  out  1  state != IDLE
- cw  out  CW_W  current CW exponent
- tx_try_complete  out  1  pulse: packet finished (success or fail)
- tx_success  out  1  valid with tx_try_complete
- tx_status  out  80  {bitmap_high[79:48], bitmap_low[47:16], ssn[15:4], num_retrans[3:0]}

Behaviour:
- Reset: state IDLE. All outputs 0, including cw and tx_status. Internal timer and num_retrans 0. Reset mid-operation abandons the packet; no completion pulse.
- States: IDLE, WAIT_TX_DONE, WAIT_ACK, RETRY, DONE. All outputs are registered.
- IDLE: on tx_start:
  - latch ack_required, is_ampdu, max_retry;
  - cw <= cw_min; num_retrans <= 0;
  - go to WAIT_TX_DONE.
- tx_start in any state other than IDLE is ignored. No latch; the current packet is unaffected.
- WAIT_TX_DONE: on phy_tx_done:
  - if !ack_required: go to DONE with success=1;
  - else: timer <= ack_timeout_cycles; go to WAIT_ACK.
- phy_tx_done outside WAIT_TX_DONE is ignored.
- WAIT_ACK, first cycle in state is T. Each cycle, priority order:
  - matching ack: rx_ack_ok when !is_ampdu, or rx_blk_ack_ok when is_ampdu. Go to DONE, success=1. For BA, latch ssn and bitmap.
  - else if timer==0: timeout.
  - else timer <= timer-1.
  - Acks are accepted at cycles T..T+ack_timeout_cycles inclusive. ack_timeout_cycles=0 gives exactly one acceptance cycle.
  - An ack in the same cycle as timer==0 wins.
  - The non-matching ack type is ignored.
- Timeout:
  - if num_retrans < max_retry: num_retrans++; cw <= (cw==cw_max || cw>cw_max) ? cw_max : cw+1 (saturating); go to RETRY.
  - else: go to DONE with success=0.
- RETRY: one cycle. retrans_req=1, then WAIT_TX_DONE.
- DONE: one cycle, then IDLE.
  - tx_try_complete=1, tx_success=success.
  - tx_status[3:0]=num_retrans.
  - SSN and bitmap fields are the latched BA values when is_ampdu && success, else 0.
  - tx_status and tx_success hold until the next DONE.
  - cw holds until the next accepted tx_start.
- Latency: ack pulse at cycle N gives tx_try_complete at N+1. Timeout at N gives retrans_req at N+1.
- max_retry=0: the first timeout completes with fail, num_retrans=0.
- num_retrans never exceeds max_retry. No 4-bit wrap is possible.

Test Plan:
1. ack_required=1, is_ampdu=0, timeout=10; rx_ack_ok 5 cycles after WAIT_ACK entry -> tx_try_complete next cycle, success=1, tx_status=80'h0, cw=cw_min.
2. max_retry=3, cw_min=4, cw_max=6, no ack ever -> three retrans_req pulses; cw goes 5,6,6; final completion success=0, tx_status[3:0]=3.
3. is_ampdu=1, rx_blk_ack_ok with ssn=12'hABC, bitmap=64'h0123_4567_89AB_CDEF after one retry -> tx_status = {64'h0123456789ABCDEF, 12'hABC, 4'd1}, success=1. An rx_ack_ok during WAIT_ACK is ignored.
4. Boundary: timeout=0, ack at T -> success. Ack at T+1 -> ignored, retry already issued. Ack coincident with timer==0 -> success, no retrans_req.
5. ack_required=0 -> completion one cycle after phy_tx_done, success=1, num_retrans=0. tx_start while busy -> ignored, latched max_retry unchanged.
6. rstn low in WAIT_ACK -> next cycle busy=0, cw=0, tx_status=0, no tx_try_complete. A new tx_start after reset runs normally.
